// File: rtl/pipelined_addsub_n.sv
// Pipelined, carry-segmented adder/subtractor: one SEG-bit slice per stage, carry registered
// between stages, valid/ready on both ends with bubble-collapsing backpressure.
module pipelined_addsub_n #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int MSB    = WIDTH - 1;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0]            valid_vec;
  logic [STAGES-1:0]            carry_vec;
  logic [STAGES-1:0][WIDTH-1:0] a_pipe;
  logic [STAGES-1:0][WIDTH-1:0] b_pipe;
  logic [STAGES-1:0][WIDTH-1:0] s_pipe;
  logic [STAGES:0]              stage_ready;

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    stage_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !valid_vec[k] | stage_ready[k+1];
    end
  end

  assign in_ready = stage_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src, b_src, s_src;
    logic             c_src, v_src;
    logic [SEG:0]     slice;
    logic             valid_q, valid_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;

    if (k == 0) begin : g_head
      // Subtraction enters as A + ~B + ~borrow.
      assign a_src = a;
      assign b_src = sub ? ~b : b;
      assign s_src = '0;
      assign c_src = sub ? ~c_in : c_in;
      assign v_src = in_valid;
    end else begin : g_body
      assign a_src = a_pipe[k-1];
      assign b_src = b_pipe[k-1];
      assign s_src = s_pipe[k-1];
      assign c_src = carry_vec[k-1];
      assign v_src = valid_vec[k-1];
    end

    assign slice = {1'b0, a_src[k*SEG +: SEG]} + {1'b0, b_src[k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_src};

    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      if (stage_ready[k]) begin
        valid_d = v_src;
        if (v_src) begin
          a_d                 = a_src;
          b_d                 = b_src;
          s_d                 = s_src;
          s_d[k*SEG +: SEG]   = slice[SEG-1:0];
          carry_d             = slice[SEG];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        s_q     <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        a_q     <= a_d;
        b_q     <= b_d;
        s_q     <= s_d;
      end
    end

    assign valid_vec[k] = valid_q;
    assign carry_vec[k] = carry_q;
    assign a_pipe[k]    = a_q;
    assign b_pipe[k]    = b_q;
    assign s_pipe[k]    = s_q;
  end

  assign out_valid = valid_vec[LAST];
  assign sum       = s_pipe[LAST];
  assign c_out     = carry_vec[LAST];
  // b_pipe carries the already-inverted operand, so this one form covers add and subtract.
  assign ovf       = (a_pipe[LAST][MSB] == b_pipe[LAST][MSB]) &
                     (s_pipe[LAST][MSB] != a_pipe[LAST][MSB]);

endmodule

// File: tb/tb_pipelined_addsub_n.sv
// Bench for pipelined_addsub_n: directed vector table, streaming/backpressure and reset
// sequences, then random traffic checked against an arithmetic scoreboard.
module tb_pipelined_addsub_n;

  localparam int W  = 16;
  localparam int SG = 4;
  localparam int ST = W / SG;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         c_in, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         c_out, ovf;

  pipelined_addsub_n #(.WIDTH(W), .SEG(SG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  exp_t         sb[$];
  exp_t         nxt;
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_pop = 0;
  bit           strict_lat = 0;
  bit           front_seen = 0;
  bit           hold_pend = 0;
  logic [W-1:0] held_s;
  logic         held_co, held_ov;

  // Reference: whole-word arithmetic, borrow and signed overflow from the operand signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb_mode);
    exp_t     e;
    logic [W:0] r;
    if (!sb_mode) begin
      r    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.co = r[W];
      e.ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
      e.co = !r[W];
      e.ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    e.s   = r[W-1:0];
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Called at a falling edge with inputs already driven; samples 1 ns later, then waits
  // for the next falling edge (the rising edge in between commits the handshakes).
  task automatic tick(output bit fired);
    bit occ_full;
    #1;
    occ_full = (sb.size() >= ST);
    chk("in_ready", {31'b0, in_ready}, {31'b0, (!occ_full || out_ready)});
    if (hold_pend) begin
      n_cmp++;
      if (out_valid !== 1'b1 || sum !== held_s || c_out !== held_co || ovf !== held_ov) begin
        n_err++;
        $display("FAIL hold: got v=%b s=%h co=%b ov=%b want v=1 s=%h co=%b ov=%b",
                 out_valid, sum, c_out, ovf, held_s, held_co, held_ov);
      end
    end
    if (sb.size() == 0) begin
      chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    end else if (out_valid === 1'b1) begin
      n_cmp++;
      if (sum !== sb[0].s || c_out !== sb[0].co || ovf !== sb[0].ov) begin
        n_err++;
        $display("FAIL result: got s=%h co=%b ov=%b want s=%h co=%b ov=%b",
                 sum, c_out, ovf, sb[0].s, sb[0].co, sb[0].ov);
      end
      if (strict_lat && !front_seen) chk("latency", cyc - sb[0].acc, ST);
      front_seen = 1;
      if (out_ready) begin
        void'(sb.pop_front());
        front_seen = 0;
        n_pop++;
      end
    end
    hold_pend = (out_valid === 1'b1) && !out_ready;
    held_s    = sum;
    held_co   = c_out;
    held_ov   = ovf;
    fired     = in_valid && in_ready;
    if (fired) begin
      nxt.acc = cyc;
      sb.push_back(nxt);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string name);
    bit f;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick(f);
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    bit   f;
    int   bi;

    tbl[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{16'h1000, 16'h0800, 1'b0, 1'b1, 16'h0800, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    nxt = model(a, b, c_in, sub);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_c_out", {31'b0, c_out}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: one beat at a time, exact latency, hand-derived results.
    strict_lat = 1;
    for (int i = 0; i < 9; i++) begin
      a = tbl[i].a; b = tbl[i].b; c_in = tbl[i].cin; sub = tbl[i].sub;
      in_valid = 1'b1;
      nxt = '{tbl[i].s, tbl[i].co, tbl[i].ov, 0};
      tick(f);
      chk("tbl_accept", {31'b0, f}, 32'd1);
      drain("tbl_timeout");
    end

    // Back-to-back burst with a long downstream stall.
    strict_lat = 0;
    n_pop = 0;
    bi = 0;
    for (int t = 0; t < 80 && (bi < 10 || sb.size() > 0); t++) begin
      out_ready = !(t >= 3 && t <= 9);
      in_valid  = (bi < 10);
      a = 16'(bi); b = 16'(2 * bi); c_in = 1'b0; sub = 1'b0;
      nxt = model(a, b, c_in, sub);
      tick(f);
      if (f) bi++;
    end
    chk("stream_accepted", bi, 10);
    chk("stream_emerged", n_pop, 10);
    drain("stream_timeout");

    // Reset with a held result plus beats in flight.
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      in_valid = (t < 3);
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0; sub = 1'b0;
      nxt = model(a, b, c_in, sub);
      tick(f);
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_sum", {16'b0, sum}, 32'd0);
    chk("midrst_c_out", {31'b0, c_out}, 32'd0);
    chk("midrst_ovf", {31'b0, ovf}, 32'd0);
    sb.delete();
    hold_pend  = 0;
    front_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) tick(f);
    strict_lat = 1;
    a = 16'h00A5; b = 16'h0F0F; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    nxt = model(a, b, c_in, sub);
    tick(f);
    chk("postrst_accept", {31'b0, f}, 32'd1);
    drain("postrst_timeout");

    // Random traffic with random backpressure.
    strict_lat = 0;
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      a    = 16'($urandom());
      b    = 16'($urandom());
      c_in = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      nxt  = model(a, b, c_in, sub);
      tick(f);
    end
    drain("rand_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
